// File: rtl/oh_pads_ctrl.sv
// oh_pads_ctrl: sequenced enable controller for one padring IO domain.
// Pads stay in a safe state (tristated, input disabled) until enable is seen.
// They are then released in staggered groups to limit simultaneous switching.
// Dropping enable returns every pad to the safe state on the next edge.
// Also holds the per-pad cfg/tech_cfg registers and synchronises pad input data.
module oh_pads_ctrl #(
    parameter int         NGPIO          = 8,
    parameter int         TECH_CFG_WIDTH = 16,
    parameter int         GROUP          = 2,
    parameter int         STAGGER        = 4,
    parameter int         SETTLE         = 16,
    parameter logic [7:0] CFG_RESET      = 8'h00,
    parameter int         AW             = (NGPIO > 1) ? $clog2(NGPIO) : 1
) (
    input  logic                            clk,
    input  logic                            nreset,
    input  logic                            enable,
    output logic                            active,
    output logic                            busy,
    input  logic                            reg_wr,
    input  logic                            reg_sel,
    input  logic [AW-1:0]                   reg_addr,
    input  logic [TECH_CFG_WIDTH-1:0]       reg_data,
    output logic                            reg_err,
    input  logic [NGPIO-1:0]                core_dout,
    input  logic [NGPIO-1:0]                core_oen,
    input  logic [NGPIO-1:0]                core_ie,
    output logic [NGPIO-1:0]                core_din,
    output logic [NGPIO-1:0]                dout,
    output logic [NGPIO-1:0]                oen,
    output logic [NGPIO-1:0]                ie,
    input  logic [NGPIO-1:0]                din,
    output logic [NGPIO*8-1:0]              cfg,
    output logic [NGPIO*TECH_CFG_WIDTH-1:0] tech_cfg
);

    // Number of release groups; the last one may be partial.
    localparam int NG      = (NGPIO + GROUP - 1) / GROUP;
    // The shared countdown covers both the settle time and the stagger gap.
    localparam int CNT_MAX = (SETTLE > STAGGER) ? SETTLE : STAGGER;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GW      = (NG > 1) ? $clog2(NG) : 1;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RAMP   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [GW-1:0]             grp_q, grp_d;
    logic [NGPIO-1:0]          rel_q, rel_d;

    logic [7:0]                cfg_q  [NGPIO];
    logic [7:0]                cfg_d  [NGPIO];
    logic [TECH_CFG_WIDTH-1:0] tech_q [NGPIO];
    logic [TECH_CFG_WIDTH-1:0] tech_d [NGPIO];
    logic                      reg_err_q, reg_err_d;
    logic                      addr_ok;

    logic [NGPIO-1:0]          sync1_q, sync2_q;

    // Pads belonging to release group k.
    function automatic logic [NGPIO-1:0] group_mask(input logic [GW-1:0] k);
        logic [NGPIO-1:0] m;
        m = '0;
        for (int i = 0; i < NGPIO; i++) begin
            m[i] = ((i / GROUP) == int'(k));
        end
        return m;
    endfunction

    // Sequencer next state: settle countdown, then one group per stagger period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        rel_d   = rel_q;
        if (!enable) begin
            // Shutdown is immediate; no reverse stagger.
            state_d = ST_OFF;
            cnt_d   = '0;
            grp_d   = '0;
            rel_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(SETTLE - 1);
                    grp_d   = '0;
                end
                ST_SETTLE, ST_RAMP: begin
                    if (cnt_q == '0) begin
                        rel_d = rel_q | group_mask(grp_q);
                        cnt_d = CW'(STAGGER - 1);
                        if (int'(grp_q) == NG - 1) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            state_d = ST_RAMP;
                            grp_d   = grp_q + GW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_ACTIVE: begin
                    state_d = ST_ACTIVE;
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    grp_d   = '0;
                    rel_d   = '0;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            grp_q   <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            rel_q   <= rel_d;
        end
    end

    // Register write decode; out-of-range pad indices only raise reg_err.
    always_comb begin
        cfg_d     = cfg_q;
        tech_d    = tech_q;
        reg_err_d = 1'b0;
        addr_ok   = (int'(reg_addr) < NGPIO);
        if (reg_wr) begin
            if (addr_ok) begin
                for (int i = 0; i < NGPIO; i++) begin
                    if (reg_addr == AW'(i)) begin
                        if (reg_sel) begin
                            tech_d[i] = reg_data;
                        end else begin
                            cfg_d[i] = reg_data[7:0];
                        end
                    end
                end
            end else begin
                reg_err_d = 1'b1;
            end
        end
    end

    // Configuration registers and error pulse.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < NGPIO; i++) begin
                cfg_q[i]  <= CFG_RESET;
                tech_q[i] <= '0;
            end
            reg_err_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            tech_q    <= tech_d;
            reg_err_q <= reg_err_d;
        end
    end

    // Two-flop synchroniser for asynchronous pad input data.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Flatten per-pad registers onto the domain buses.
    always_comb begin
        cfg      = '0;
        tech_cfg = '0;
        for (int i = 0; i < NGPIO; i++) begin
            cfg[i*8 +: 8]                             = cfg_q[i];
            tech_cfg[i*TECH_CFG_WIDTH +: TECH_CFG_WIDTH] = tech_q[i];
        end
    end

    // Unreleased pads are forced tristate with input disabled.
    assign dout     = core_dout;
    assign oen      = core_oen | ~rel_q;
    assign ie       = core_ie & rel_q;
    assign core_din = sync2_q & rel_q;
    assign busy     = (state_q == ST_SETTLE) || (state_q == ST_RAMP);
    assign active   = (state_q == ST_ACTIVE);
    assign reg_err  = reg_err_q;

endmodule

// File: tb/tb_oh_pads_ctrl.sv
// tb_oh_pads_ctrl: directed stimulus with a cycle-tagged expectation queue.
// Stimulus pushes (cycle, signal, value) records; the monitor pops and compares
// them on the falling edge once the matching rising edge has occurred.
module tb_oh_pads_ctrl;

    localparam int NGPIO = 8;
    localparam int TW    = 16;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              nreset;
    logic              enable;
    logic              active, busy, reg_err;
    logic              reg_wr, reg_sel;
    logic [AW-1:0]     reg_addr;
    logic [TW-1:0]     reg_data;
    logic [NGPIO-1:0]  core_dout, core_oen, core_ie, core_din;
    logic [NGPIO-1:0]  dout, oen, ie, din;
    logic [NGPIO*8-1:0]  cfg;
    logic [NGPIO*TW-1:0] tech_cfg;

    oh_pads_ctrl #(
        .NGPIO(NGPIO), .TECH_CFG_WIDTH(TW), .GROUP(3), .STAGGER(4),
        .SETTLE(16), .CFG_RESET(8'h5A), .AW(AW)
    ) dut (
        .clk(clk), .nreset(nreset), .enable(enable), .active(active), .busy(busy),
        .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_addr(reg_addr), .reg_data(reg_data),
        .reg_err(reg_err), .core_dout(core_dout), .core_oen(core_oen),
        .core_ie(core_ie), .core_din(core_din), .dout(dout), .oen(oen), .ie(ie),
        .din(din), .cfg(cfg), .tech_cfg(tech_cfg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_OEN = 0, S_IE = 1, S_BUSY = 2, S_ACT = 3, S_CDIN = 4;
    localparam int S_CFG = 6, S_TECH = 7, S_ERR = 8, S_DOUT = 9;

    typedef struct {
        int           at;
        int           id;
        logic [127:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [127:0] sample(input int id);
        case (id)
            S_OEN:   return 128'(oen);
            S_IE:    return 128'(ie);
            S_BUSY:  return 128'(busy);
            S_ACT:   return 128'(active);
            S_CDIN:  return 128'(core_din);
            S_CFG:   return 128'(cfg);
            S_TECH:  return 128'(tech_cfg);
            S_ERR:   return 128'(reg_err);
            S_DOUT:  return 128'(dout);
            default: return '0;
        endcase
    endfunction

    function automatic string name_of(input int id);
        case (id)
            S_OEN:   return "oen";
            S_IE:    return "ie";
            S_BUSY:  return "busy";
            S_ACT:   return "active";
            S_CDIN:  return "core_din";
            S_CFG:   return "cfg";
            S_TECH:  return "tech_cfg";
            S_ERR:   return "reg_err";
            S_DOUT:  return "dout";
            default: return "unknown";
        endcase
    endfunction

    task automatic ex(input int at, input int id, input logic [127:0] v);
        chk_t e;
        e.at  = at;
        e.id  = id;
        e.exp = v;
        sb.push_back(e);
    endtask

    // Advance to just after rising edge n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due at the current edge count.
    initial begin
        chk_t         e;
        logic [127:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                act = sample(e.id);
                if (e.at < cyc) begin
                    n_err++;
                    $display("FAIL %s: check for edge %0d missed (now %0d)", name_of(e.id), e.at, cyc);
                end else if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s @edge %0d: got %0h, expected %0h", name_of(e.id), cyc, act, e.exp);
                end
            end
        end
    end

    localparam logic [63:0] CFG_RST = 64'h5A5A5A5A5A5A5A5A;
    localparam logic [63:0] CFG_W5  = 64'h5A5AC35A5A5A5A5A;

    initial begin
        // Reset held with enable and a write pending: reset must win.
        nreset    = 1'b0;
        enable    = 1'b1;
        reg_wr    = 1'b1;
        reg_sel   = 1'b0;
        reg_addr  = '0;
        reg_data  = 16'h00FF;
        core_dout = 8'h3C;
        core_oen  = 8'h00;
        core_ie   = 8'hFF;
        din       = 8'hA5;

        ex(2, S_OEN, 8'hFF);  ex(2, S_IE, 8'h00);   ex(2, S_BUSY, 1'b0);
        ex(2, S_ACT, 1'b0);   ex(2, S_CFG, CFG_RST); ex(2, S_TECH, '0);
        ex(2, S_CDIN, 8'h00); ex(2, S_ERR, 1'b0);
        ex(3, S_OEN, 8'hFF);  ex(3, S_CFG, CFG_RST); ex(3, S_BUSY, 1'b0);
        ex(3, S_DOUT, 8'h3C);
        goto(2);
        nreset = 1'b1;
        enable = 1'b0;
        reg_wr = 1'b0;

        // Ramp: enable first sampled at edge 10.
        goto(9);
        ex(9,  S_BUSY, 1'b0); ex(9,  S_OEN, 8'hFF);
        ex(10, S_BUSY, 1'b1); ex(10, S_OEN, 8'hFF); ex(10, S_ACT, 1'b0);
        ex(25, S_OEN, 8'hFF); ex(25, S_CDIN, 8'h00);
        ex(26, S_OEN, 8'hF8); ex(26, S_IE, 8'h07); ex(26, S_CDIN, 8'h05); ex(26, S_BUSY, 1'b1);
        ex(29, S_OEN, 8'hF8);
        ex(30, S_OEN, 8'hC0); ex(30, S_IE, 8'h3F); ex(30, S_CDIN, 8'h25);
        ex(33, S_ACT, 1'b0);  ex(33, S_BUSY, 1'b1); ex(33, S_OEN, 8'hC0);
        ex(34, S_OEN, 8'h00); ex(34, S_IE, 8'hFF); ex(34, S_ACT, 1'b1);
        ex(34, S_BUSY, 1'b0); ex(34, S_CDIN, 8'hA5);
        ex(37, S_CDIN, 8'hA5);
        ex(38, S_CDIN, 8'h5A);
        ex(40, S_OEN, 8'hFF); ex(40, S_IE, 8'h00); ex(40, S_ACT, 1'b0);
        ex(40, S_BUSY, 1'b0); ex(40, S_CDIN, 8'h00);
        enable = 1'b1;
        goto(36);
        din = 8'h5A;
        goto(39);
        enable = 1'b0;

        // Abort: start at 50, drop at 68, re-enable at 80.
        goto(49);
        ex(49, S_BUSY, 1'b0);
        ex(50, S_BUSY, 1'b1);
        ex(66, S_OEN, 8'hF8);
        ex(67, S_OEN, 8'hF8); ex(67, S_BUSY, 1'b1);
        ex(68, S_OEN, 8'hFF); ex(68, S_IE, 8'h00); ex(68, S_BUSY, 1'b0);
        ex(68, S_ACT, 1'b0);  ex(68, S_CDIN, 8'h00);
        ex(79, S_BUSY, 1'b0); ex(79, S_OEN, 8'hFF);
        ex(80, S_BUSY, 1'b1);
        ex(95, S_OEN, 8'hFF);
        ex(96, S_OEN, 8'hF8); ex(96, S_BUSY, 1'b1); ex(96, S_CDIN, 8'h02);
        enable = 1'b1;
        goto(67);
        enable = 1'b0;
        goto(79);
        enable = 1'b1;

        // Single-edge enable pulse at 110: SETTLE then OFF, nothing released.
        goto(99);
        ex(100, S_OEN, 8'hFF); ex(100, S_BUSY, 1'b0);
        ex(110, S_BUSY, 1'b1); ex(110, S_OEN, 8'hFF);
        ex(111, S_BUSY, 1'b0);
        ex(130, S_OEN, 8'hFF); ex(130, S_BUSY, 1'b0);
        enable = 1'b0;
        goto(109);
        enable = 1'b1;
        goto(110);
        enable = 1'b0;

        // Registers: cfg pad 5, tech_cfg pad 7, then out-of-range pad 9.
        goto(139);
        ex(139, S_CFG, CFG_RST); ex(139, S_ERR, 1'b0);
        ex(140, S_CFG, CFG_W5);  ex(140, S_TECH, '0); ex(140, S_ERR, 1'b0);
        ex(141, S_TECH, {16'hBEEF, 112'h0}); ex(141, S_CFG, CFG_W5); ex(141, S_ERR, 1'b0);
        ex(142, S_ERR, 1'b1); ex(142, S_CFG, CFG_W5); ex(142, S_TECH, {16'hBEEF, 112'h0});
        ex(143, S_ERR, 1'b0); ex(143, S_CFG, CFG_W5);
        reg_wr   = 1'b1;
        reg_sel  = 1'b0;
        reg_addr = 4'd5;
        reg_data = 16'h00C3;
        goto(140);
        reg_sel  = 1'b1;
        reg_addr = 4'd7;
        reg_data = 16'hBEEF;
        goto(141);
        reg_sel  = 1'b0;
        reg_addr = 4'd9;
        reg_data = 16'h0011;
        goto(142);
        reg_wr   = 1'b0;

        goto(150);
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        while (sb.size() > 0) begin
            chk_t e;
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: check for edge %0d never reached", name_of(e.id), e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oh_pads_ctrl.md
# oh_pads_ctrl

Sequenced controller for one padring IO domain. It holds per-pad configuration registers and releases pads from a safe tristated state in staggered groups after enable, to limit simultaneous switching at power-up. On disable it returns every pad to the safe state in one cycle. Sits between core logic and an IO domain instance, and drives that instance's `oen`/`ie`/`dout`/`cfg`/`tech_cfg` and receives its `din`.

## Interface
- NGPIO, 8: pads in the domain, 1 to 64.
- TECH_CFG_WIDTH, 16: per-pad tech config width, at least 8.
- GROUP, 2: pads released per ramp step, 1 to NGPIO.
- STAGGER, 4: cycles between ramp steps, at least 1.
- SETTLE, 16: cycles from enable to the first release, at least 1.
- CFG_RESET, 8'h00: reset value of every `cfg` byte.
- AW, $clog2(NGPIO) with a minimum of 1: register address width.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- enable  in  1  level; high requests the domain active.
- active  out  1  all pads released.
- busy  out  1  in SETTLE or RAMP.
- reg_wr  in  1  register write strobe.
- reg_sel  in  1  0 = cfg (uses reg_data[7:0]), 1 = tech_cfg.
- reg_addr  in  AW  pad index.
- reg_data  in  TECH_CFG_WIDTH  write data.
- reg_err  out  1  one-cycle pulse on a write with reg_addr >= NGPIO.
- core_dout  in  NGPIO  data from core.
- core_oen  in  NGPIO  core output enable (bar).
- core_ie  in  NGPIO  core input enable.
- core_din  out  NGPIO  synchronised pad data to core.
- dout  out  NGPIO  to pads, equal to core_dout (combinational).
- oen  out  NGPIO  to pads.
- ie  out  NGPIO  to pads.
- din  in  NGPIO  from pads, asynchronous.
- cfg  out  NGPIO*8  per-pad config, pad i at [i*8+:8].
- tech_cfg  out  NGPIO*TECH_CFG_WIDTH  per-pad tech config.

## Operation
- States:
  - OFF: no pads released.
  - SETTLE: counting down before the first release.
  - RAMP: releasing groups.
  - ACTIVE: all pads released.
- Internal `rel[NGPIO]` release mask.
  - Gating: `oen[i] = core_oen[i] | ~rel[i]`; `ie[i] = core_ie[i] & rel[i]`.
  - A pad that is not released is therefore tristated with its input disabled.
- Group count NG = ceil(NGPIO/GROUP). Group k covers pads k*GROUP up to min((k+1)*GROUP, NGPIO)-1. The last group may be partial.
- State transitions:
  - OFF to SETTLE when enable is sampled 1. The counter loads SETTLE-1.
  - SETTLE: when the counter reaches 0, set group 0 bits in rel. Go to RAMP, or to ACTIVE if NG == 1.
  - RAMP: every STAGGER cycles, set the next group's bits. The edge that sets the last group enters ACTIVE.
  - Any state with enable sampled 0: go to OFF next edge. rel, counter, active and busy all clear on that same edge. There is no staggered shutdown.
  - Re-enable after OFF restarts from SETTLE.
- Register writes:
  - Accepted in any state.
  - New value is visible on `cfg`/`tech_cfg` the edge after reg_wr.
  - A write with reg_addr >= NGPIO is ignored and raises reg_err for one cycle.
- core_din: 2-flop synchroniser on din, then ANDed with rel.
- Reset values:
  - state OFF; rel 0.
  - oen = all 1; ie = 0.
  - active 0, busy 0, reg_err 0.
  - cfg = CFG_RESET per pad; tech_cfg 0.
  - synchroniser flops 0, so core_din = 0.
- Reset wins over enable and reg_wr in the same cycle.

## Timing
- Let enable be first sampled 1 at edge t while in OFF.
  - busy = 1 from edge t to the edge where ACTIVE is entered.
  - Group k bits set at edge t+SETTLE+k*STAGGER.
  - active = 1 at edge t+SETTLE+(NG-1)*STAGGER.
- Enable sampled 0 at edge u: rel = 0, oen = all 1 and active = 0 after edge u.
- Enable high for only one edge: SETTLE is entered, then OFF the next edge; no pad is released.
- din to core_din latency: 2 edges, plus masking by rel.
- oen, ie and dout respond combinationally to core inputs.

## Test plan
- Reset: NGPIO=8, CFG_RESET=8'h5A. After nreset is released, oen=8'hFF, ie=0, each cfg byte is 8'h5A, tech_cfg=0, and active, busy and core_din are all 0.
- Ramp: GROUP=3, STAGGER=4, SETTLE=16, enable sampled at edge 0. Then rel=8'h07 at edge 16, 8'h3F at edge 20, 8'hFF at edge 24. active rises at edge 24 and busy falls at edge 24.
- Abort: same ramp setup, enable drops at edge 18. After edge 18, oen=8'hFF, ie=0 and busy=0. Re-enable at edge 30 gives the first release at edge 46.
- Registers: write cfg pad 5 with 8'hC3, then tech_cfg pad 7 with 16'hBEEF, then reg_addr=9. cfg[47:40]=8'hC3, tech_cfg[127:112]=16'hBEEF, and reg_err pulses for exactly one cycle with no register changed.
- Gating and sync: while ACTIVE with core_oen=0 and core_ie=8'hFF, din=8'hA5 gives core_din=8'hA5 two edges later. In OFF, core_din=0 and oen=8'hFF regardless of core_oen.
